uart_tx_periph: RTL and testbench



---
 rtl/uart_tx_periph.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter on the CPU data bus.
//
// Stores to DATA (BASE_ADDR) push data_in[7:0] into a FIFO. A bit-serial FSM
// drains the FIFO LSB first on tx. STATUS (BASE_ADDR+4) is readable with one
// cycle of registered latency. A store to STATUS clears the sticky overflow flag.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   address    CPU data address
//   data_in    CPU store data; only [7:0] is transmitted
//   width      byte enables; only bit 0 qualifies a store
//   write      store strobe
//   read_data  registered STATUS value, or zero for any other address
//   tx         serial line, idle high
//   busy       frame on the line or bytes waiting in the FIFO
module uart_tx_periph #(
  parameter logic [9:0]  BASE_ADDR    = 10'h3F0,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  address,
  input  logic [31:0] data_in,
  input  logic [3:0]  width,
  input  logic        write,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BitCntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [9:0]         StatusAddr = BASE_ADDR + 10'd4;
  localparam logic [BitCntW-1:0] BitLast    = BitCntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]    FifoFull   = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q;
  logic [BitCntW-1:0] bit_cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q;

  logic fifo_empty, fifo_full, bit_end, tx_active;
  logic push_req, push, pop, status_wr;
  logic [3:0]  count_sat;
  logic [31:0] status;

  // Only the low byte and byte-enable bit 0 matter.
  logic unused_bits;
  assign unused_bits = ^{width[3:1], data_in[31:8]};

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FifoFull);
  assign bit_end    = (bit_cnt_q == BitLast);
  assign tx_active  = (state_q != StIdle);
  assign busy       = tx_active || !fifo_empty;

  // Pop only from a non-empty FIFO: a push into an empty FIFO lands first and
  // is popped on the following cycle.
  assign pop = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));

  assign push_req  = write && width[0] && (address == BASE_ADDR);
  assign status_wr = write && width[0] && (address == StatusAddr);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push      = push_req && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in[7:0];
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      if (push_req && !push) begin
        overflow_q <= 1'b1;
      end else if (status_wr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Transmit FSM; tx is registered and changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx        <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx <= 1'b1;
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            bit_cnt_q <= '0;
            state_q   <= StStart;
            tx        <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
            tx        <= shift_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              tx      <= 1'b1;
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              tx        <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (pop) begin
              // Back-to-back frame: straight into the next start bit.
              shift_q <= mem_q[rd_ptr_q];
              state_q <= StStart;
              tx      <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx      <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          tx      <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    count_sat = 4'd15;
    if (32'(count_q) < 32'd16) begin
      count_sat = 4'(count_q);
    end
  end

  assign status = {24'b0, count_sat, overflow_q, fifo_empty, fifo_full, tx_active};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
    end else if (address == StatusAddr) begin
      read_data <= status;
    end else begin
      read_data <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
module tb_uart_tx_periph;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [9:0]  BASE  = 10'h3F0;
  localparam logic [9:0]  STAT  = BASE + 10'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  width = '0;
  logic        write = 1'b0;
  logic [31:0] read_data;
  logic        tx;
  logic        busy;

  int total = 0;
  int bad = 0;
  int rst_events = 0;
  logic [7:0] sb[$];

  uart_tx_periph #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_in  (data_in),
    .width    (width),
    .write    (write),
    .read_data(read_data),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge rst_n) rst_events++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    write = 1'b0;
    address = '0;
    width = '0;
    #1;
    repeat (3) tick();
    rst_n = 1'b1;
    sb.delete();
    tick();
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d, input logic [3:0] w);
    address = a;
    data_in = d;
    width = w;
    write = 1'b1;
    tick();
    write = 1'b0;
    address = '0;
    width = '0;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    address = STAT;
    tick();
    check(name, read_data, exp);
    address = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (busy || sb.size() != 0) begin
      bad++;
      $display("FAIL %s: busy=%0b pending=%0d after %0d cycles, want busy=0 pending=0",
               name, busy, sb.size(), n);
    end
  endtask

  // Line receiver: samples each bit 1.5 cycles past its start edge and
  // compares each frame against the scoreboard.
  initial begin : rx_mon
    logic [7:0] b;
    logic       ok;
    int         rst_at;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        rst_at = rst_events;
        ok = 1'b1;
        @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        if (rst_at == rst_events) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL rx_unexpected: got frame 0x%0h, want no frame", b);
          end else begin
            e = sb.pop_front();
            if (b !== e || !ok) begin
              bad++;
              $display("FAIL rx_frame: got 0x%0h framing_ok=%0b, want 0x%0h framing_ok=1",
                       b, ok, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic        wr;
    logic [9:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    logic [9:0] pat;
    int lows;

    vecs[0] = '{addr: STAT, wdata: 32'h0,  wen: 4'b0000, wr: 1'b0, rd_addr: STAT, exp_rd: 32'h04};
    vecs[1] = '{addr: BASE, wdata: 32'h0,  wen: 4'b0000, wr: 1'b0, rd_addr: BASE, exp_rd: 32'h00};
    vecs[2] = '{addr: BASE, wdata: 32'h7E, wen: 4'b0010, wr: 1'b1, rd_addr: STAT, exp_rd: 32'h04};
    vecs[3] = '{addr: BASE + 10'd8, wdata: 32'h7E, wen: 4'b0001, wr: 1'b1, rd_addr: STAT,
                exp_rd: 32'h04};
    vecs[4] = '{addr: STAT, wdata: 32'hFF, wen: 4'b0001, wr: 1'b1, rd_addr: STAT, exp_rd: 32'h04};
    vecs[5] = '{addr: BASE, wdata: 32'h7E, wen: 4'b0001, wr: 1'b0, rd_addr: STAT, exp_rd: 32'h04};
    vecs[6] = '{addr: 10'h000, wdata: 32'h0, wen: 4'b0000, wr: 1'b0, rd_addr: 10'h000,
                exp_rd: 32'h00};

    // Reset state
    rst_n = 1'b0;
    #1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    do_reset();

    // Ignored stores and address decode
    for (int i = 0; i < 7; i++) begin
      address = vecs[i].addr;
      data_in = vecs[i].wdata;
      width = vecs[i].wen;
      write = vecs[i].wr;
      tick();
      write = 1'b0;
      address = vecs[i].rd_addr;
      tick();
      check($sformatf("vec%0d_read", i), read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_tx", i), {31'b0, tx}, 32'd1);
      check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd0);
    end
    address = '0;

    // Single frame 0x55
    do_reset();
    sb.push_back(8'h55);
    store(BASE, 32'h55, 4'b0001);
    check("t1_tx_before_fall", {31'b0, tx}, 32'd1);
    check("t1_busy_on_store", {31'b0, busy}, 32'd1);
    tick();
    pat = 10'b1010101010;
    check("t1_bit0", {31'b0, tx}, {31'b0, pat[0]});
    for (int k = 1; k < 10; k++) begin
      repeat (CPB) tick();
      check($sformatf("t1_bit%0d", k), {31'b0, tx}, {31'b0, pat[k]});
    end
    repeat (CPB - 1) tick();
    check("t1_busy_at_39", {31'b0, busy}, 32'd1);
    tick();
    check("t1_busy_at_40", {31'b0, busy}, 32'd0);
    check("t1_tx_idle", {31'b0, tx}, 32'd1);
    drain("t1_drain", 50);

    // Back-to-back frames
    do_reset();
    sb.push_back(8'hA3);
    sb.push_back(8'h0F);
    store(BASE, 32'hA3, 4'b0001);
    store(BASE, 32'h0F, 4'b0001);
    check("t2_fall", {31'b0, tx}, 32'd0);
    repeat (10 * CPB - 1) tick();
    check("t2_stop1", {31'b0, tx}, 32'd1);
    tick();
    check("t2_start2", {31'b0, tx}, 32'd0);
    repeat (10 * CPB - 1) tick();
    check("t2_busy_at_79", {31'b0, busy}, 32'd1);
    tick();
    check("t2_busy_at_80", {31'b0, busy}, 32'd0);
    drain("t2_drain", 50);

    // Overflow and clear
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(8'(8'h10 + i));
      store(BASE, 32'(8'h10 + i), 4'b0001);
    end
    read_status("t3_status_ovf", 32'h8B);
    store(STAT, 32'hFFFF_FFFF, 4'b0001);
    read_status("t3_status_clr", 32'h83);
    drain("t3_drain", 9 * 10 * CPB + 100);
    read_status("t3_status_idle", 32'h04);

    // Reset mid-frame
    do_reset();
    store(BASE, 32'h11, 4'b0001);
    store(BASE, 32'h22, 4'b0001);
    store(BASE, 32'h33, 4'b0001);
    repeat (CPB) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_tx_async", {31'b0, tx}, 32'd1);
    check("t4_busy_async", {31'b0, busy}, 32'd0);
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    read_status("t4_status", 32'h04);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx == 1'b0 || busy) lows++;
    end
    check("t4_no_frames", lows, 32'd0);

    // Store on the exact cycle STOP pops, with the FIFO full
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sb.push_back(8'(8'hC0 + i));
      store(BASE, 32'(8'hC0 + i), 4'b0001);
    end
    read_status("t5_full", 32'h83);
    repeat (10 * CPB - 9) tick();
    sb.push_back(8'hE7);
    store(BASE, 32'hE7, 4'b0001);
    read_status("t5_after_pop_store", 32'h83);
    drain("t5_drain", 10 * 10 * CPB + 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
